// File: rtl/vcve2_vrf_agu.sv
// Address generation unit for the memory-mapped vector register file: turns register
// indices and LMUL into word addresses and keeps one running element pointer per operand.
// Optional feature: define VCVE2_AGU_BOUNDS_CHECK_EN to saturate pointers at the end of
// their register group and raise a sticky ovf_o instead of wrapping.
module vcve2_vrf_agu #(
    parameter int unsigned VLEN          = 128,
    parameter int unsigned PIPE_WIDTH    = 32,
    parameter int unsigned AddrWidth     = 5,
    parameter logic [31:0] VRF_BASE_ADDR = 32'h0000_1000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    input  logic [AddrWidth-1:0] raddr_b_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [2:0]           lmul_i,
    input  logic                 get_rs1_i,
    input  logic                 get_rs2_i,
    input  logic                 get_rd_i,
    input  logic                 incr_i,
    output logic                 ready_o,
    output logic [31:0]          addr_o,
    output logic                 err_o,
    output logic                 ovf_o
);

    localparam int unsigned   RegShift = $clog2(VLEN / 8);
    localparam int unsigned   OffW     = $clog2(VLEN) + 1;
    localparam logic [OffW-1:0] Step     = OffW'(PIPE_WIDTH / 8);
    localparam logic [OffW-1:0] RegBytes = OffW'(VLEN / 8);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC_A = 3'd1;
    localparam logic [2:0] CALC_B = 3'd2;
    localparam logic [2:0] CALC_D = 3'd3;
    localparam logic [2:0] READY  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] idx_a_q, idx_a_d;
    logic [AddrWidth-1:0] idx_b_q, idx_b_d;
    logic [AddrWidth-1:0] idx_d_q, idx_d_d;
    logic [OffW-1:0]      gb_q, gb_d;
    logic                 err_q, err_d;
    logic [31:0]          base_a_q, base_a_d;
    logic [31:0]          base_b_q, base_b_d;
    logic [31:0]          base_d_q, base_d_d;
    logic [OffW-1:0]      off_a_q, off_a_d;
    logic [OffW-1:0]      off_b_q, off_b_d;
    logic [OffW-1:0]      off_d_q, off_d_d;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
    logic                 ovf_q, ovf_d;
`endif

    // Group size and alignment are decided once, from the raw inputs, in the load cycle.
    logic [OffW-1:0] load_gb;
    logic [2:0]      grp_mask;
    logic            load_err;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        load_gb  = RegBytes;
        grp_mask = 3'b000;
        load_err = 1'b0;
        case (lmul_i)
            3'b001: begin load_gb = RegBytes << 1; grp_mask = 3'b001; end
            3'b010: begin load_gb = RegBytes << 2; grp_mask = 3'b011; end
            3'b011: begin load_gb = RegBytes << 3; grp_mask = 3'b111; end
            3'b111: load_gb = RegBytes >> 1;
            3'b110: load_gb = RegBytes >> 2;
            3'b101: load_gb = RegBytes >> 3;
            3'b100: load_err = 1'b1;
            default: ;
        endcase
        if (load_gb < Step) begin
            load_gb = Step;
        end
        if (|((raddr_a_i[2:0] | raddr_b_i[2:0] | waddr_i[2:0]) & grp_mask)) begin
            load_err = 1'b1;
        end
    end

    logic [AddrWidth-1:0] calc_idx;
    logic [31:0]          calc_base;

    always_comb begin
        case (state_q)
            CALC_B:  calc_idx = idx_b_q;
            CALC_D:  calc_idx = idx_d_q;
            default: calc_idx = idx_a_q;
        endcase
    end

    assign calc_base = VRF_BASE_ADDR + (32'(calc_idx) << RegShift);

    logic            sel_a, sel_b, sel_d;
    logic            incr_en;
    logic [OffW-1:0] off_sel, off_inc, off_next;
    logic            at_end;

    assign sel_a   = get_rs1_i;
    assign sel_b   = ~get_rs1_i & get_rs2_i;
    assign sel_d   = ~get_rs1_i & ~get_rs2_i & get_rd_i;
    assign incr_en = incr_i & ~load_i & (state_q == READY) & (sel_a | sel_b | sel_d);

    assign off_sel = sel_a ? off_a_q : (sel_b ? off_b_q : off_d_q);
    assign off_inc = off_sel + Step;
    assign at_end  = (off_inc >= gb_q);

`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
    assign off_next = at_end ? off_sel : off_inc;
`else
    assign off_next = at_end ? '0 : off_inc;
`endif

    always_comb begin
        state_d  = state_q;
        idx_a_d  = idx_a_q;
        idx_b_d  = idx_b_q;
        idx_d_d  = idx_d_q;
        gb_d     = gb_q;
        err_d    = err_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_d_d = base_d_q;
        off_a_d  = off_a_q;
        off_b_d  = off_b_q;
        off_d_d  = off_d_q;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
        ovf_d    = ovf_q;
`endif
        // A load restarts from any state and overrides a coincident increment.
        if (load_i) begin
            state_d = CALC_A;
            idx_a_d = raddr_a_i;
            idx_b_d = raddr_b_i;
            idx_d_d = waddr_i;
            gb_d    = load_gb;
            err_d   = load_err;
            off_a_d = '0;
            off_b_d = '0;
            off_d_d = '0;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                CALC_A: begin base_a_d = calc_base; state_d = CALC_B; end
                CALC_B: begin base_b_d = calc_base; state_d = CALC_D; end
                CALC_D: begin base_d_d = calc_base; state_d = READY;  end
                IDLE, READY: ;
                default: state_d = IDLE;
            endcase
            if (incr_en) begin
                if (sel_a) off_a_d = off_next;
                if (sel_b) off_b_d = off_next;
                if (sel_d) off_d_d = off_next;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
                if (at_end) ovf_d = 1'b1;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state logic lives above.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            idx_d_q  <= '0;
            gb_q     <= '0;
            err_q    <= 1'b0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            off_a_q  <= '0;
            off_b_q  <= '0;
            off_d_q  <= '0;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            idx_d_q  <= idx_d_d;
            gb_q     <= gb_d;
            err_q    <= err_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            off_a_q  <= off_a_d;
            off_b_q  <= off_b_d;
            off_d_q  <= off_d_d;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        addr_o = '0;
        if (sel_a) begin
            addr_o = base_a_q + 32'(off_a_q);
        end else if (sel_b) begin
            addr_o = base_b_q + 32'(off_b_q);
        end else if (sel_d) begin
            addr_o = base_d_q + 32'(off_d_q);
        end
    end

    assign ready_o = (state_q == READY);
    assign err_o   = err_q;

`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Self-checking bench for vcve2_vrf_agu: directed scenarios plus randomized loads and
// pointer walks, all checked against an arithmetic model of group size and pointer motion.
module tb_vcve2_vrf_agu;

    localparam int unsigned VLEN  = 128;
    localparam int unsigned PW    = 32;
    localparam int unsigned AW    = 5;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          STEP  = PW / 8;
    localparam int          REGB  = VLEN / 8;
`ifdef VCVE2_AGU_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          load_i = 1'b0;
    logic [AW-1:0] raddr_a_i = '0;
    logic [AW-1:0] raddr_b_i = '0;
    logic [AW-1:0] waddr_i = '0;
    logic [2:0]    lmul_i = '0;
    logic          get_rs1_i = 1'b0;
    logic          get_rs2_i = 1'b0;
    logic          get_rd_i = 1'b0;
    logic          incr_i = 1'b0;
    logic          ready_o;
    logic [31:0]   addr_o;
    logic          err_o;
    logic          ovf_o;

    vcve2_vrf_agu #(
        .VLEN(VLEN), .PIPE_WIDTH(PW), .AddrWidth(AW), .VRF_BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .waddr_i(waddr_i), .lmul_i(lmul_i),
        .get_rs1_i(get_rs1_i), .get_rs2_i(get_rs2_i), .get_rd_i(get_rd_i), .incr_i(incr_i),
        .ready_o(ready_o), .addr_o(addr_o), .err_o(err_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: operand 0 = rs1, 1 = rs2, 2 = rd.
    logic [31:0] m_base[3];
    int          m_off[3];
    int          m_gb;
    bit          m_err;
    bit          m_ovf;
    bit          m_ready;

    function automatic int lmul_log2(input logic [2:0] l);
        if (l == 3'b100) return 0;
        return l[2] ? int'(l) - 8 : int'(l);
    endfunction

    function automatic int gb_of(input logic [2:0] l);
        int s = lmul_log2(l);
        int g = (s >= 0) ? REGB * (1 << s) : REGB / (1 << (-s));
        return (g < STEP) ? STEP : g;
    endfunction

    function automatic bit err_of(input logic [2:0] l, input int a, input int b, input int d);
        int s = lmul_log2(l);
        int n;
        if (l == 3'b100) return 1'b1;
        if (s <= 0) return 1'b0;
        n = 1 << s;
        return (a % n != 0) || (b % n != 0) || (d % n != 0);
    endfunction

    function automatic logic [31:0] exp_addr(input int sel);
        if (sel > 2) return 32'h0;
        return m_base[sel] + 32'(m_off[sel]);
    endfunction

    task automatic model_step(input int sel);
        int o;
        if (!m_ready || sel > 2) return;
        o = m_off[sel] + STEP;
        if (o >= m_gb) begin
            if (BoundsEn) m_ovf = 1'b1;
            else m_off[sel] = 0;
        end else begin
            m_off[sel] = o;
        end
    endtask

    task automatic set_get(input int sel);
        get_rs1_i = (sel == 0);
        get_rs2_i = (sel == 1);
        get_rd_i  = (sel == 2);
    endtask

    task automatic do_load(input int a, input int b, input int d, input logic [2:0] l,
                           input bit with_incr);
        @(negedge clk_i);
        load_i = 1'b1;
        raddr_a_i = AW'(a);
        raddr_b_i = AW'(b);
        waddr_i = AW'(d);
        lmul_i = l;
        if (with_incr) begin
            set_get(0);
            incr_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        load_i = 1'b0;
        incr_i = 1'b0;
        set_get(3);
        m_base[0] = BASE + 32'(a * REGB);
        m_base[1] = BASE + 32'(b * REGB);
        m_base[2] = BASE + 32'(d * REGB);
        m_off = '{0, 0, 0};
        m_gb = gb_of(l);
        m_err = err_of(l, a, b, d);
        m_ovf = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic do_incr(input int sel);
        @(negedge clk_i);
        set_get(sel);
        incr_i = 1'b1;
        @(posedge clk_i);
        #1;
        incr_i = 1'b0;
        set_get(3);
        model_step(sel);
    endtask

    task automatic read_addr(input int sel, output logic [31:0] a);
        @(negedge clk_i);
        set_get(sel);
        #1;
        a = addr_o;
        set_get(3);
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_ready_timeout: ready_o got 0 within 16 cycles, expected 1", tag);
        end
        m_ready = 1'b1;
    endtask

    // ready_o must be low in cycles 1..3 after the load and high in cycle 4.
    task automatic check_latency(input string tag);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            vectors++;
            if (ready_o !== (c == 4)) begin
                miscompares++;
                $display("FAIL %s_ready_c%0d: got %b expected %b", tag, c, ready_o, (c == 4));
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic check_all_ptrs(input string tag);
        logic [31:0] a;
        for (int s = 0; s < 4; s++) begin
            read_addr(s, a);
            vectors++;
            if (a !== exp_addr(s)) begin
                miscompares++;
                $display("FAIL %s_addr_sel%0d: got %h expected %h", tag, s, a, exp_addr(s));
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] a;
        #3;
        vectors += 3;
        if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
        if (err_o !== 1'b0)   begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_o); end
        if (ovf_o !== 1'b0)   begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
        get_rs1_i = 1'b1;
        #1;
        a = addr_o;
        get_rs1_i = 1'b0;
        vectors++;
        if (a !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", a); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] a;
        logic [31:0] exp_tab[4] = '{32'h1020, 32'h1040, 32'h1060, 32'h0};
        do_load(2, 4, 6, 3'b000, 1'b0);
        check_latency("basic");
        for (int s = 0; s < 4; s++) begin
            read_addr(s, a);
            vectors++;
            if (a !== exp_tab[s]) begin
                miscompares++;
                $display("FAIL basic_addr_sel%0d: got %h expected %h", s, a, exp_tab[s]);
            end
        end
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b expected 0", err_o); end
    endtask

    task automatic test_stepping();
        logic [31:0] a;
        logic [31:0] last;
        for (int k = 0; k < 4; k++) begin
            read_addr(0, a);
            vectors++;
            if (a !== 32'h1020 + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL step_rs1_%0d: got %h expected %h", k, a, 32'h1020 + 32'(4 * k));
            end
            do_incr(0);
        end
        last = BoundsEn ? 32'h102C : 32'h1020;
        read_addr(0, a);
        vectors += 2;
        if (a !== last) begin miscompares++; $display("FAIL step_rs1_end: got %h expected %h", a, last); end
        if (ovf_o !== BoundsEn) begin miscompares++; $display("FAIL step_ovf: got %b expected %b", ovf_o, BoundsEn); end
        check_all_ptrs("step");
        do_incr(1);
        vectors++;
        if (ovf_o !== BoundsEn) begin miscompares++; $display("FAIL step_ovf_sticky: got %b expected %b", ovf_o, BoundsEn); end
    endtask

    task automatic test_lmul2();
        logic [31:0] a;
        logic [31:0] last;
        do_load(3, 0, 0, 3'b001, 1'b0);
        wait_ready("lmul2_bad");
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL lmul2_err_odd: got %b expected 1", err_o); end
        do_load(4, 6, 8, 3'b001, 1'b0);
        wait_ready("lmul2_ok");
        vectors += 2;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL lmul2_err_even: got %b expected 0", err_o); end
        if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL lmul2_ovf_cleared: got %b expected 0", ovf_o); end
        for (int k = 0; k < 8; k++) begin
            read_addr(0, a);
            vectors++;
            if (a !== 32'h1040 + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL lmul2_rs1_%0d: got %h expected %h", k, a, 32'h1040 + 32'(4 * k));
            end
            do_incr(0);
        end
        last = BoundsEn ? 32'h105C : 32'h1040;
        read_addr(0, a);
        vectors++;
        if (a !== last) begin miscompares++; $display("FAIL lmul2_rs1_end: got %h expected %h", a, last); end
    endtask

    task automatic test_fractional();
        logic [31:0] a;
        logic [31:0] exp_tab[3];
        exp_tab = '{32'h1010, 32'h1014, BoundsEn ? 32'h1014 : 32'h1010};
        do_load(0, 0, 1, 3'b111, 1'b0);
        wait_ready("frac");
        vectors++;
        if (err_o !== 1'b0) begin miscompares++; $display("FAIL frac_err: got %b expected 0", err_o); end
        for (int k = 0; k < 3; k++) begin
            read_addr(2, a);
            vectors++;
            if (a !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL frac_rd_%0d: got %h expected %h", k, a, exp_tab[k]);
            end
            if (k < 2) do_incr(2);
        end
        do_load(2, 3, 5, 3'b100, 1'b0);
        wait_ready("reserved");
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("FAIL reserved_err: got %b expected 1", err_o); end
        do_incr(0);
        check_all_ptrs("reserved");
    endtask

    task automatic test_hazards();
        logic [31:0] a;
        do_load(1, 2, 3, 3'b000, 1'b0);
        @(posedge clk_i);
        #1;
        do_load(9, 10, 11, 3'b000, 1'b0);
        check_latency("reload");
        check_all_ptrs("reload");
        do_incr(0);
        do_incr(0);
        do_load(12, 13, 14, 3'b000, 1'b1);
        wait_ready("load_incr");
        check_all_ptrs("load_incr");
        do_incr(1);
        do_incr(3);
        check_all_ptrs("no_get");
        do_load(5, 7, 9, 3'b000, 1'b0);
        do_incr(0);
        wait_ready("calc_incr");
        read_addr(0, a);
        vectors++;
        if (a !== BASE + 32'h50) begin miscompares++; $display("FAIL calc_incr_rs1: got %h expected %h", a, BASE + 32'h50); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int it = 0; it < 24; it++) begin
            do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b0);
            wait_ready("rand");
            vectors++;
            if (err_o !== m_err) begin miscompares++; $display("FAIL rand_err_%0d: got %b expected %b", it, err_o, m_err); end
            for (int op = 0; op < 16; op++) begin
                int sel = int'($urandom_range(0, 3));
                if ($urandom_range(0, 2) != 0) begin
                    do_incr(sel);
                end else begin
                    read_addr(sel, a);
                    vectors += 2;
                    if (a !== exp_addr(sel)) begin
                        miscompares++;
                        $display("FAIL rand_addr_%0d_%0d: got %h expected %h", it, op, a, exp_addr(sel));
                    end
                    if (ovf_o !== m_ovf) begin
                        miscompares++;
                        $display("FAIL rand_ovf_%0d_%0d: got %b expected %b", it, op, ovf_o, m_ovf);
                    end
                end
            end
            check_all_ptrs("rand_end");
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] a;
        do_load(9, 10, 11, 3'b000, 1'b0);
        wait_ready("pre_rst");
        do_load(3, 5, 7, 3'b010, 1'b0);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        vectors += 3;
        if (ready_o !== 1'b0) begin miscompares++; $display("FAIL arst_ready: got %b expected 0", ready_o); end
        if (err_o !== 1'b0)   begin miscompares++; $display("FAIL arst_err: got %b expected 0", err_o); end
        if (ovf_o !== 1'b0)   begin miscompares++; $display("FAIL arst_ovf: got %b expected 0", ovf_o); end
        m_base = '{32'h0, 32'h0, 32'h0};
        m_off = '{0, 0, 0};
        m_ready = 1'b0;
        check_all_ptrs("arst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            vectors++;
            if (ready_o !== 1'b0) begin miscompares++; $display("FAIL arst_idle_%0d: got %b expected 0", c, ready_o); end
        end
        read_addr(2, a);
        vectors++;
        if (a !== 32'h0) begin miscompares++; $display("FAIL arst_rd_after: got %h expected 0", a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stepping();
        test_lmul2();
        test_fractional();
        test_hazards();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1);
    end

endmodule
